// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, FSM state encoding, per-line event bundle.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam int I2C_BCNT_W = 3;

    // Line indices into the conditioned-line array.
    localparam int LN_SCL    = 0;
    localparam int LN_SDA    = 1;
    localparam int NUM_LINES = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_t;

    // Synchronized level plus one-clk edge strobes for one bus line.
    typedef struct packed {
        logic lvl;
        logic rise;
        logic fall;
    } i2c_line_t;

endpackage

// File: rtl/i2c_target_if.sv
// Pin-side and fabric-side signals of the I2C target, bundled.
interface i2c_target_if;
    import i2c_pkg::*;

    logic                  i2c_scl_in;
    logic                  i2c_sda_in;
    logic                  i2c_sda_oe;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic                  tx_req;
    logic                  busy;

    // Target side.
    modport slave (
        input  i2c_scl_in, i2c_sda_in, tx_data,
        output i2c_sda_oe, rx_data, rx_valid, tx_req, busy
    );

    // Bus controller / fabric side.
    modport master (
        output i2c_scl_in, i2c_sda_in, tx_data,
        input  i2c_sda_oe, rx_data, rx_valid, tx_req, busy
    );

endinterface

// File: rtl/i2c_line_sync.sv
// 2-FF synchronizer for one asynchronous bus line plus rise/fall strobes.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      din,
    output i2c_line_t ln
);

    // [0] metastability stage, [1] synchronized level, [2] previous level.
    logic [2:0] sync_q;

    // Shift the raw pin in; reset to the idle-high bus level so no edge is seen.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 3'b111;
        else       sync_q <= {sync_q[1:0], din};
    end

    // Edge strobes compare the synchronized level with its registered copy.
    always_comb begin
        ln.lvl  = sync_q[1];
        ln.rise = sync_q[1] & ~sync_q[2];
        ln.fall = ~sync_q[1] & sync_q[2];
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: START/STOP detect, fixed address match, byte write/read with ACK.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h42
) (
    input logic         clk,
    input logic         reset,
    i2c_target_if.slave bus
);

    logic      [NUM_LINES-1:0] pin;
    i2c_line_t [NUM_LINES-1:0] ln;

    assign pin[LN_SCL] = bus.i2c_scl_in;
    assign pin[LN_SDA] = bus.i2c_sda_in;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_sync
        i2c_line_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (pin[g]),
            .ln    (ln[g])
        );
    end

    logic scl_rise, scl_fall, sda, start_det, stop_det;

    assign scl_rise = ln[LN_SCL].rise;
    assign scl_fall = ln[LN_SCL].fall;
    assign sda      = ln[LN_SDA].lvl;
    // An SDA edge coincident with an SCL edge is data, never START/STOP.
    assign start_det = ln[LN_SDA].fall & ln[LN_SCL].lvl & ~scl_rise & ~scl_fall;
    assign stop_det  = ln[LN_SDA].rise & ln[LN_SCL].lvl & ~scl_rise & ~scl_fall;

    i2c_state_t            state, state_n;
    logic [I2C_BYTE_W-1:0] shreg, shreg_n;
    logic [I2C_BCNT_W-1:0] bit_cnt, bit_cnt_n;
    logic                  rw_q, rw_n;
    // Phase flag inside the two-fall ACK states; in RD_ACK it marks "ACK seen".
    logic                  ack_q, ack_n;
    logic                  oe_q, oe_n;
    logic                  busy_q, busy_n;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_n;
    logic                  rx_valid_q, rx_valid_n;
    logic                  tx_req_q, tx_req_n;

    // State and datapath registers; reset releases SDA on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            rw_q       <= rw_n;
            ack_q      <= ack_n;
            oe_q       <= oe_n;
            busy_q     <= busy_n;
            rx_data_q  <= rx_data_n;
            rx_valid_q <= rx_valid_n;
            tx_req_q   <= tx_req_n;
        end
    end

    // Next state and register updates; START/STOP override any bit handling.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        rw_n       = rw_q;
        ack_n      = ack_q;
        oe_n       = oe_q;
        busy_n     = busy_q;
        rx_data_n  = rx_data_q;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;

        if (stop_det) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            ack_n   = 1'b0;
        end else if (start_det) begin
            state_n   = ST_ADDR;
            bit_cnt_n = '0;
            oe_n      = 1'b0;
            ack_n     = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[I2C_BYTE_W-2:0], sda};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw_n    = sda;
                            ack_n   = 1'b0;
                            state_n = (shreg[I2C_ADDR_W-1:0] == ADDR) ? ST_ADDR_ACK
                                                                      : ST_WAIT_STOP;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            ack_n    = 1'b1;
                            oe_n     = 1'b1;
                            busy_n   = 1'b1;
                            tx_req_n = rw_q;
                        end else begin
                            ack_n     = 1'b0;
                            bit_cnt_n = '0;
                            if (rw_q) begin
                                shreg_n = bus.tx_data;
                                oe_n    = ~bus.tx_data[I2C_BYTE_W-1];
                                state_n = ST_RD_DATA;
                            end else begin
                                oe_n    = 1'b0;
                                state_n = ST_WR_DATA;
                            end
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = {shreg[I2C_BYTE_W-2:0], sda};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n  = {shreg[I2C_BYTE_W-2:0], sda};
                            rx_valid_n = 1'b1;
                            ack_n      = 1'b0;
                            state_n    = ST_WR_ACK;
                        end
                    end
                end

                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            ack_n = 1'b1;
                            oe_n  = 1'b1;
                        end else begin
                            ack_n   = 1'b0;
                            oe_n    = 1'b0;
                            state_n = ST_WR_DATA;
                        end
                    end
                end

                ST_RD_DATA: begin
                    // MSB went out on entry; each fall rotates the next bit into [7].
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            oe_n    = 1'b0;
                            ack_n   = 1'b0;
                            state_n = ST_RD_ACK;
                        end else begin
                            shreg_n = {shreg[I2C_BYTE_W-2:0], shreg[I2C_BYTE_W-1]};
                            oe_n    = ~shreg[I2C_BYTE_W-2];
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (!ack_q) begin
                        if (scl_rise) begin
                            if (!sda) begin
                                ack_n    = 1'b1;
                                tx_req_n = 1'b1;
                            end else begin
                                state_n = ST_WAIT_STOP;
                            end
                        end
                    end else if (scl_fall) begin
                        ack_n     = 1'b0;
                        bit_cnt_n = '0;
                        shreg_n   = bus.tx_data;
                        oe_n      = ~bus.tx_data[I2C_BYTE_W-1];
                        state_n   = ST_RD_DATA;
                    end
                end

                default: begin
                    // IDLE and WAIT_STOP keep SDA released and wait for START/STOP.
                    oe_n = 1'b0;
                end
            endcase
        end
    end

    assign bus.i2c_sda_oe = oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_req     = tx_req_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller on a wired-AND bus, write vector
// table, hand-written read / repeated-START / abort / reset sequences.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int         QC  = 10;       // clk per quarter SCL period
    localparam logic [6:0] OWN = 7'h42;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_drv = 1'b1;
    logic sda_ctl = 1'b1;
    logic oe_prev = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int tx_req_cnt = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_src[$];
    logic [7:0] rd_exp[$];
    logic [7:0] mon_b;

    i2c_target_if bus();

    i2c_target #(.ADDR(OWN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.i2c_scl_in = scl_drv;
    assign bus.i2c_sda_in = sda_ctl & ~bus.i2c_sda_oe;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    // Fabric side + scoreboard: pop expected rx bytes, hand out tx bytes on tx_req.
    always @(negedge clk) begin
        if (!reset && bus.rx_valid) begin
            if (rx_exp.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL rx_unexpected: got %02h want none", bus.rx_data);
            end else begin
                mon_b = rx_exp.pop_front();
                chk8("rx_data", bus.rx_data, mon_b);
            end
        end
        if (!reset && bus.tx_req) begin
            tx_req_cnt++;
            if (tx_src.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL tx_req_unexpected: got pulse want none");
            end else begin
                mon_b = tx_src.pop_front();
                bus.tx_data = mon_b;
                rd_exp.push_back(mon_b);
            end
        end
        if (bus.i2c_sda_oe && !oe_prev)
            chk1("oe_rise_while_scl_low", scl_drv, 1'b0);
        oe_prev = bus.i2c_sda_oe;
    end

    task automatic q();
        repeat (QC) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic s);
        sda_ctl = b;  q();
        scl_drv = 1'b1; q();
        s = bus.i2c_sda_in; q();
        scl_drv = 1'b0; q();
    endtask

    task automatic byte_x(input logic [7:0] wr, input logic ninth,
                          output logic [7:0] rd, output logic ninth_s);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_x(wr[i], s);
            rd[i] = s;
        end
        bit_x(ninth, ninth_s);
    endtask

    task automatic do_start();
        sda_ctl = 1'b1; q();
        scl_drv = 1'b1; q();
        sda_ctl = 1'b0; q();
        scl_drv = 1'b0; q();
    endtask

    task automatic do_stop();
        sda_ctl = 1'b0; q();
        scl_drv = 1'b1; q();
        sda_ctl = 1'b1; q();
        q();
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] got);
        if (rd_exp.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL %s: got %02h want no read byte", nm, got);
        end else begin
            chk8(nm, got, rd_exp.pop_front());
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk1({nm, "_oe"},   bus.i2c_sda_oe, 1'b0);
        chk1({nm, "_busy"}, bus.busy, 1'b0);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
    } wvec_t;

    initial begin
        wvec_t      tbl[6];
        logic [7:0] rd;
        logic       s;
        int         cnt0;

        tbl[0] = '{7'h42, 8'hA5, 1'b1};
        tbl[1] = '{7'h43, 8'h5A, 1'b0};
        tbl[2] = '{7'h42, 8'h00, 1'b1};
        tbl[3] = '{7'h42, 8'hFF, 1'b1};
        tbl[4] = '{7'h02, 8'h33, 1'b0};
        tbl[5] = '{7'h21, 8'h77, 1'b0};

        // Reset values.
        repeat (4) @(negedge clk);
        chk1("rst_oe", bus.i2c_sda_oe, 1'b0);
        chk8("rst_rx_data", bus.rx_data, 8'h00);
        chk1("rst_rx_valid", bus.rx_valid, 1'b0);
        chk1("rst_tx_req", bus.tx_req, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        q();

        // Write vectors: address + one data byte + STOP.
        for (int i = 0; i < 6; i++) begin
            do_start();
            byte_x({tbl[i].addr, 1'b0}, 1'b1, rd, s);
            chk1("addr_ack", !s, tbl[i].exp_ack);
            chk1("busy_after_addr", bus.busy, tbl[i].exp_ack);
            if (tbl[i].exp_ack) rx_exp.push_back(tbl[i].data);
            byte_x(tbl[i].data, 1'b1, rd, s);
            chk1("data_ack", !s, tbl[i].exp_ack);
            do_stop();
            chk_idle_outputs("after_stop");
        end

        // Read two bytes: ACK the first, NACK the second.
        tx_src.push_back(8'h3C);
        tx_src.push_back(8'hC3);
        cnt0 = tx_req_cnt;
        do_start();
        byte_x({OWN, 1'b1}, 1'b1, rd, s);
        chk1("rd_addr_ack", !s, 1'b1);
        chk1("rd_busy", bus.busy, 1'b1);
        byte_x(8'hFF, 1'b0, rd, s);
        rd_chk("rd_byte0", rd);
        byte_x(8'hFF, 1'b1, rd, s);
        rd_chk("rd_byte1", rd);
        chk1("rd_oe_released_before_stop", bus.i2c_sda_oe, 1'b0);
        do_stop();
        chk8("rd_tx_req_count", 8'(tx_req_cnt - cnt0), 8'd2);
        chk_idle_outputs("rd_after_stop");

        // Write 0x11, repeated START, read one byte.
        tx_src.push_back(8'h5A);
        cnt0 = tx_req_cnt;
        do_start();
        byte_x({OWN, 1'b0}, 1'b1, rd, s);
        chk1("rs_waddr_ack", !s, 1'b1);
        rx_exp.push_back(8'h11);
        byte_x(8'h11, 1'b1, rd, s);
        chk1("rs_wdata_ack", !s, 1'b1);
        do_start();
        byte_x({OWN, 1'b1}, 1'b1, rd, s);
        chk1("rs_raddr_ack", !s, 1'b1);
        byte_x(8'hFF, 1'b1, rd, s);
        rd_chk("rs_rd_byte", rd);
        do_stop();
        chk8("rs_tx_req_count", 8'(tx_req_cnt - cnt0), 8'd1);
        chk_idle_outputs("rs_after_stop");

        // STOP after 4 bits of a write byte: partial byte dropped.
        do_start();
        byte_x({OWN, 1'b0}, 1'b1, rd, s);
        chk1("ab_addr_ack", !s, 1'b1);
        bit_x(1'b1, s);
        bit_x(1'b0, s);
        bit_x(1'b1, s);
        bit_x(1'b1, s);
        do_stop();
        chk_idle_outputs("ab_after_stop");
        chk8("ab_state_idle", {5'd0, dut.state}, {5'd0, ST_IDLE});
        // Bus must still work after the abort.
        do_start();
        byte_x({OWN, 1'b0}, 1'b1, rd, s);
        chk1("ab2_addr_ack", !s, 1'b1);
        rx_exp.push_back(8'h6B);
        byte_x(8'h6B, 1'b1, rd, s);
        chk1("ab2_data_ack", !s, 1'b1);
        do_stop();

        // Reset while the target pulls SDA low for a read bit.
        tx_src.push_back(8'h00);
        do_start();
        byte_x({OWN, 1'b1}, 1'b1, rd, s);
        chk1("rr_addr_ack", !s, 1'b1);
        chk1("rr_oe_driving_zero", bus.i2c_sda_oe, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk1("rr_oe", bus.i2c_sda_oe, 1'b0);
        chk8("rr_rx_data", bus.rx_data, 8'h00);
        chk1("rr_rx_valid", bus.rx_valid, 1'b0);
        chk1("rr_tx_req", bus.tx_req, 1'b0);
        chk1("rr_busy", bus.busy, 1'b0);
        reset = 1'b0;
        rd_exp.delete();
        q();
        do_stop();
        chk_idle_outputs("rr_after_stop");

        // Scoreboard must be drained.
        chk8("rx_exp_left", 8'(rx_exp.size()), 8'd0);
        chk8("tx_src_left", 8'(tx_src.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
